// File: rtl/flit_credit_tx.sv
//------------------------------------------------------------------------------
// Module  : flit_credit_tx
// Brief   : Router FIFO drain stage with credit-based flow control and a
//           registered link output.
// Rev     : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module flit_credit_tx #(
  parameter int WIDTH   = 544,
  parameter int CREDITS = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [WIDTH-1:0]           fifo_data,
  input  logic                       fifo_empty,
  output logic                       fifo_re,
  input  logic                       link_en,
  input  logic                       credit_return,
  output logic                       link_valid,
  output logic [WIDTH-1:0]           link_data,
  output logic [$clog2(CREDITS):0]   credit_cnt,
  output logic [1:0]                 state,
  output logic [31:0]                flit_cnt,
  output logic                       err_credit
);

  localparam int CW = $clog2(CREDITS) + 1;

  localparam logic [CW-1:0] c_credits   = CW'(CREDITS);
  localparam logic [1:0]    c_idle      = 2'd0;
  localparam logic [1:0]    c_send      = 2'd1;
  localparam logic [1:0]    c_wait_cred = 2'd2;

  logic             r_link_valid;
  logic [WIDTH-1:0] r_link_data;
  logic [CW-1:0]    r_credit_cnt;
  logic [1:0]       r_state;
  logic [31:0]      r_flit_cnt;
  logic             r_err_credit;

  logic             w_send;
  logic [CW-1:0]    w_credit_nxt;
  logic             w_overflow;
  logic [1:0]       w_state_nxt;

  assign w_send  = ~rst & link_en & ~fifo_empty & (r_credit_cnt != '0);
  assign fifo_re = w_send;

  // A simultaneous send and return cancel out; a return at full saturates.
  always_comb begin
    w_credit_nxt = r_credit_cnt;
    w_overflow   = 1'b0;
    if (w_send && !credit_return) begin
      w_credit_nxt = r_credit_cnt - CW'(1);
    end else if (!w_send && credit_return) begin
      if (r_credit_cnt == c_credits) begin
        w_overflow = 1'b1;
      end else begin
        w_credit_nxt = r_credit_cnt + CW'(1);
      end
    end
  end

  always_comb begin
    w_state_nxt = c_idle;
    if (w_send) begin
      w_state_nxt = c_send;
    end else if ((w_credit_nxt == '0) && !fifo_empty) begin
      w_state_nxt = c_wait_cred;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_link_valid <= 1'b0;
      r_link_data  <= '0;
      r_credit_cnt <= c_credits;
      r_state      <= c_idle;
      r_flit_cnt   <= '0;
      r_err_credit <= 1'b0;
    end else begin
      r_link_valid <= w_send;
      if (w_send) begin
        r_link_data <= fifo_data;
        r_flit_cnt  <= r_flit_cnt + 32'd1;
      end
      r_credit_cnt <= w_credit_nxt;
      r_state      <= w_state_nxt;
      if (w_overflow) begin
        r_err_credit <= 1'b1;
      end
    end
  end

  assign link_valid = r_link_valid;
  assign link_data  = r_link_data;
  assign credit_cnt = r_credit_cnt;
  assign state      = r_state;
  assign flit_cnt   = r_flit_cnt;
  assign err_credit = r_err_credit;

endmodule

`default_nettype wire

// File: tb/tb_flit_credit_tx.sv
//------------------------------------------------------------------------------
// Module  : tb_flit_credit_tx
// Brief   : Scoreboard bench for flit_credit_tx with a behavioural source FIFO.
// Rev     : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_flit_credit_tx;

  localparam int WIDTH   = 544;
  localparam int CREDITS = 4;

  logic             clk;
  logic             rst;
  logic [WIDTH-1:0] fifo_data;
  logic             fifo_empty;
  logic             fifo_re;
  logic             link_en;
  logic             credit_return;
  logic             link_valid;
  logic [WIDTH-1:0] link_data;
  logic [2:0]       credit_cnt;
  logic [1:0]       state;
  logic [31:0]      flit_cnt;
  logic             err_credit;

  logic [WIDTH-1:0] fifo_q[$];
  logic [WIDTH-1:0] exp_q[$];
  int               n_cmp;
  int               n_err;
  int               re_count;
  int               re_mark;
  logic             pop_now;

  flit_credit_tx #(.WIDTH(WIDTH), .CREDITS(CREDITS)) u_dut (
    .clk           (clk),
    .rst           (rst),
    .fifo_data     (fifo_data),
    .fifo_empty    (fifo_empty),
    .fifo_re       (fifo_re),
    .link_en       (link_en),
    .credit_return (credit_return),
    .link_valid    (link_valid),
    .link_data     (link_data),
    .credit_cnt    (credit_cnt),
    .state         (state),
    .flit_cnt      (flit_cnt),
    .err_credit    (err_credit)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [WIDTH-1:0] mk_flit(input int idx);
    logic [31:0] w;
    w = 32'hA5C30000 | 32'(idx);
    return {17{w}};
  endfunction

  task automatic refresh();
    fifo_empty = (fifo_q.size() == 0);
    fifo_data  = fifo_empty ? '0 : fifo_q[0];
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic push_flits(input int first, input int count);
    for (int i = 0; i < count; i++) fifo_q.push_back(mk_flit(first + i));
    refresh();
  endtask

  // Source FIFO pops after the DUT has sampled its head; expected flits queued on the pop.
  always @(posedge clk) begin
    pop_now = fifo_re;
    if (fifo_re) begin
      exp_q.push_back(fifo_data);
      re_count++;
    end
    #1;
    if (pop_now && fifo_q.size() > 0) void'(fifo_q.pop_front());
    refresh();
  end

  // Every popped flit must be on the link one cycle later, and nothing else.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      check("link_valid", {543'd0, link_valid}, 544'd1);
      check("link_data", link_data, exp_q.pop_front());
    end else begin
      check("link_idle", {543'd0, link_valid}, 544'd0);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_cmp = 0; n_err = 0; re_count = 0;
    rst = 1'b1; link_en = 1'b0; credit_return = 1'b0;
    refresh();

    // Reset then idle
    tick(2);
    rst = 1'b0;
    tick(1);
    check("rst_credit", 544'(credit_cnt), 544'd4);
    check("rst_state", 544'(state), 544'd0);
    check("rst_re", 544'(fifo_re), 544'd0);
    check("rst_flit_cnt", 544'(flit_cnt), 544'd0);
    check("rst_err", 544'(err_credit), 544'd0);

    // Burst until credits run out
    push_flits(0, 6);
    link_en = 1'b1;
    re_mark = re_count;
    tick(8);
    check("burst_re_count", 544'(re_count - re_mark), 544'd4);
    check("burst_credit", 544'(credit_cnt), 544'd0);
    check("burst_state", 544'(state), 544'd2);
    check("burst_flit_cnt", 544'(flit_cnt), 544'd4);
    credit_return = 1'b1;
    tick(1);
    credit_return = 1'b0;
    check("cred_ret_cnt", 544'(credit_cnt), 544'd1);
    check("cred_ret_re", 544'(fifo_re), 544'd1);
    tick(1);
    check("e_valid", 544'(link_valid), 544'd1);
    check("e_data", link_data, mk_flit(4));
    check("e_credit", 544'(credit_cnt), 544'd0);
    check("e_state", 544'(state), 544'd1);
    check("e_flit_cnt", 544'(flit_cnt), 544'd5);

    // Simultaneous send and credit return
    link_en = 1'b0;
    credit_return = 1'b1;
    tick(2);
    check("pre_sim_credit", 544'(credit_cnt), 544'd2);
    check("pre_sim_state", 544'(state), 544'd0);
    link_en = 1'b1;
    tick(1);
    credit_return = 1'b0;
    check("sim_credit", 544'(credit_cnt), 544'd2);
    check("sim_flit_cnt", 544'(flit_cnt), 544'd6);

    // Credit overflow
    credit_return = 1'b1;
    tick(2);
    credit_return = 1'b0;
    check("full_credit", 544'(credit_cnt), 544'd4);
    check("full_err", 544'(err_credit), 544'd0);
    credit_return = 1'b1;
    tick(1);
    credit_return = 1'b0;
    check("ovf_credit", 544'(credit_cnt), 544'd4);
    check("ovf_err", 544'(err_credit), 544'd1);
    tick(3);
    check("ovf_err_sticky", 544'(err_credit), 544'd1);

    // Pause with flits pending
    link_en = 1'b0;
    push_flits(6, 3);
    re_mark = re_count;
    for (int i = 0; i < 5; i++) begin
      #1;
      check("pause_re", 544'(fifo_re), 544'd0);
      tick(1);
      check("pause_hold", link_data, mk_flit(5));
    end
    check("pause_re_count", 544'(re_count - re_mark), 544'd0);
    link_en = 1'b1;
    tick(4);
    check("resume_re_count", 544'(re_count - re_mark), 544'd3);
    check("resume_credit", 544'(credit_cnt), 544'd1);
    check("resume_flit_cnt", 544'(flit_cnt), 544'd9);
    check("resume_last", link_data, mk_flit(8));

    // Reset in the middle of a burst
    link_en = 1'b0;
    credit_return = 1'b1;
    tick(3);
    credit_return = 1'b0;
    check("pre_rst_credit", 544'(credit_cnt), 544'd4);
    push_flits(9, 4);
    link_en = 1'b1;
    tick(2);
    check("mid_flit_cnt", 544'(flit_cnt), 544'd11);
    rst = 1'b1;
    #1;
    check("rst_mid_re", 544'(fifo_re), 544'd0);
    tick(1);
    check("rst_mid_valid", 544'(link_valid), 544'd0);
    check("rst_mid_credit", 544'(credit_cnt), 544'd4);
    check("rst_mid_flit_cnt", 544'(flit_cnt), 544'd0);
    check("rst_mid_err", 544'(err_credit), 544'd0);
    check("rst_mid_state", 544'(state), 544'd0);
    fifo_q.delete();
    refresh();
    link_en = 1'b0;
    rst = 1'b0;
    tick(2);
    check("final_valid", 544'(link_valid), 544'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
